// File: rtl/nios_buttons_pkg.sv
// Shared register map and edge-type encodings for the push-button controller.
package nios_buttons_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_PERIOD  = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/nios_button_debounce_bit.sv
// One button lane: two-flop synchroniser followed by a counting debouncer that
// only accepts a new level after it has been held for `period` cycles.
module nios_button_debounce_bit
  import nios_buttons_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pin,
  input  logic [CNT_W-1:0] period,
  input  logic             clear_cnt,
  output logic             stable
);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_inc;

  // Extra bit keeps the +1 from wrapping when period is at its maximum.
  assign cnt_inc = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};

  // stage p0/p1: metastability synchroniser
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pin;
      sync_p1 <= sync_p0;
    end
  end

  // stage p2: debounce; a period of 0 or 1 degenerates to a plain one-cycle delay
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (clear_cnt) begin
      cnt <= '0;
    end else if (sync_p1 == stable) begin
      cnt <= '0;
    end else if (cnt_inc >= {1'b0, period}) begin
      stable <= sync_p1;
      cnt    <= '0;
    end else begin
      cnt <= cnt_inc[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/nios_buttons_debounce_irq_ctrl.sv
// Avalon-MM push-button controller: debounced levels, sticky edge capture and a
// maskable level interrupt for the Nios.
module nios_buttons_debounce_irq_ctrl
  import nios_buttons_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CNT_W        = 20,
  parameter int DEBOUNCE_RST = 50000,
  parameter int EDGE_TYPE    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port
);

  logic             wr_en;
  logic             wr_irqmask;
  logic             wr_edgecap;
  logic             wr_period;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [CNT_W-1:0] period;
  logic [31:0]      rd_next;
  logic             unused_writedata;

  function automatic logic [WIDTH-1:0] select_edges(input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] prev);
    case (EDGE_TYPE)
      EDGE_RISING:  return cur & ~prev;
      EDGE_FALLING: return ~cur & prev;
      default:      return cur ^ prev;
    endcase
  endfunction

  assign wr_en      = chipselect & ~write_n;
  assign wr_irqmask = wr_en && (address == ADDR_IRQMASK);
  assign wr_edgecap = wr_en && (address == ADDR_EDGECAP);
  assign wr_period  = wr_en && (address == ADDR_PERIOD);
  assign edge_clr   = wr_edgecap ? writedata[WIDTH-1:0] : '0;
  assign unused_writedata = ^writedata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    nios_button_debounce_bit #(
      .CNT_W (CNT_W)
    ) u_bit (
      .clk       (clk),
      .reset     (reset),
      .pin       (in_port[g]),
      .period    (period),
      .clear_cnt (wr_period),
      .stable    (stable[g])
    );
  end

  // stage p3: edge detection against the previous debounced level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_d <= '0;
    end else begin
      stable_d <= stable;
    end
  end

  assign edge_hit = select_edges(stable, stable_d);

  // A new edge in the same cycle as a clearing write wins, so no event is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edgecap <= '0;
    end else begin
      edgecap <= (edgecap & ~edge_clr) | edge_hit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqmask <= '0;
      period  <= CNT_W'(DEBOUNCE_RST);
    end else begin
      if (wr_irqmask) irqmask <= writedata[WIDTH-1:0];
      if (wr_period)  period  <= writedata[CNT_W-1:0];
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:    rd_next[WIDTH-1:0] = stable;
      ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap;
      ADDR_PERIOD:  rd_next[CNT_W-1:0] = period;
      default:      rd_next = '0;
    endcase
  end

  // Read data is registered on every edge regardless of chipselect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_nios_buttons_debounce_irq_ctrl.sv
// Self-checking bench for the push-button controller with a window-based reference model.
module tb_nios_buttons_debounce_irq_ctrl;

  localparam int WIDTH   = 4;
  localparam int CNT_W   = 20;
  localparam int DEB_RST = 50000;
  localparam int EDGE_T  = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       address = 2'd0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic             irq;
  logic [WIDTH-1:0] in_port = '0;

  always #5 clk = ~clk;

  nios_buttons_debounce_irq_ctrl #(
    .WIDTH        (WIDTH),
    .CNT_W        (CNT_W),
    .DEBOUNCE_RST (DEB_RST),
    .EDGE_TYPE    (EDGE_T)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .in_port    (in_port)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  logic [WIDTH-1:0] m_stable, m_stable_d, m_edgecap, m_mask;
  logic [CNT_W-1:0] m_period;
  logic [31:0]      m_rd;
  int               ecnt;
  int               last_clear;
  logic [WIDTH-1:0] hist[$];

  task automatic model_reset();
    m_stable   = '0;
    m_stable_d = '0;
    m_edgecap  = '0;
    m_mask     = '0;
    m_period   = CNT_W'(DEB_RST);
    m_rd       = '0;
    ecnt       = 0;
    last_clear = 0;
    hist.delete();
  endtask

  function automatic logic pin_at(int k, int b);
    if (k < 1 || k > hist.size()) return 1'b0;
    return hist[k-1][b];
  endfunction

  // A level is accepted once the synchronised pin (pin sampled two edges
  // earlier) has shown the opposite value for `period` consecutive edges
  // since the last PERIOD write.
  task automatic model_edge(input logic [WIDTH-1:0] pin, input logic cs, input logic wn,
                            input logic [1:0] addr, input logic [31:0] wd);
    logic [WIDTH-1:0] nxt, hit, clr;
    logic             wr;
    int               peff;
    bit               all_diff;
    ecnt++;
    hist.push_back(pin);
    wr = cs && !wn;
    case (addr)
      2'd0:    m_rd = {28'd0, m_stable};
      2'd1:    m_rd = {28'd0, m_mask};
      2'd2:    m_rd = {28'd0, m_edgecap};
      default: m_rd = {12'd0, m_period};
    endcase
    case (EDGE_T)
      0:       hit = m_stable & ~m_stable_d;
      1:       hit = ~m_stable & m_stable_d;
      default: hit = m_stable ^ m_stable_d;
    endcase
    nxt = m_stable;
    if (!(wr && addr == 2'd3)) begin
      for (int b = 0; b < WIDTH; b++) begin
        peff = (m_period < 2) ? 1 : int'(m_period);
        if (ecnt - peff >= last_clear) begin
          all_diff = 1'b1;
          for (int j = 0; j < peff; j++) begin
            if (pin_at(ecnt - 2 - j, b) == m_stable[b]) begin
              all_diff = 1'b0;
              break;
            end
          end
          if (all_diff) nxt[b] = ~m_stable[b];
        end
      end
    end
    clr = (wr && addr == 2'd2) ? wd[WIDTH-1:0] : '0;
    m_edgecap = (m_edgecap & ~clr) | hit;
    if (wr && addr == 2'd1) m_mask = wd[WIDTH-1:0];
    if (wr && addr == 2'd3) begin
      m_period   = wd[CNT_W-1:0];
      last_clear = ecnt;
    end
    m_stable_d = m_stable;
    m_stable   = nxt;
  endtask

  // Advance one clock: inputs were driven at the previous negedge.
  task automatic tick();
    logic [WIDTH-1:0] pin_s = in_port;
    logic             cs_s = chipselect;
    logic             wn_s = write_n;
    logic [1:0]       ad_s = address;
    logic [31:0]      wd_s = writedata;
    @(posedge clk);
    model_edge(pin_s, cs_s, wn_s, ad_s, wd_s);
    @(negedge clk);
  endtask

  task automatic av_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_rd[4];
    exp_rd[0] = 32'd0;
    exp_rd[1] = 32'd0;
    exp_rd[2] = 32'd0;
    exp_rd[3] = 32'd50000;
    do_reset();
    n_total++;
    if (readdata !== 32'd0) $display("FAIL reset_readdata got=%0h exp=0", readdata);
    else n_pass++;
    n_total++;
    if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq);
    else n_pass++;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      tick();
      n_total++;
      if (readdata !== exp_rd[a]) $display("FAIL reset_read addr=%0d got=%0d exp=%0d", a, readdata, exp_rd[a]);
      else n_pass++;
    end
    n_total++;
    if (irq !== 1'b0) $display("FAIL reset_irq_after_reads got=%b exp=0", irq);
    else n_pass++;
  endtask

  task automatic test_clean_edge();
    av_write(2'd3, 32'd10);
    in_port = 4'hF;
    repeat (20) tick();
    av_write(2'd2, 32'hF);
    address = 2'd2;
    tick();
    n_total++;
    if (readdata !== 32'd0) $display("FAIL clean_edgecap_cleared got=%0h exp=0", readdata);
    else n_pass++;
    in_port[0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 13) begin
        n_total++;
        if (readdata[0] !== 1'b0) $display("FAIL clean_edge_early k=13 got=%b exp=0", readdata[0]);
        else n_pass++;
      end
      if (k == 14) begin
        n_total++;
        if (readdata[0] !== 1'b1) $display("FAIL clean_edge_latency k=14 got=%b exp=1", readdata[0]);
        else n_pass++;
      end
      n_total++;
      if (readdata !== m_rd || irq !== 1'b0)
        $display("FAIL clean_edge_cycle k=%0d rd=%0h exp=%0h irq=%b exp=0", k, readdata, m_rd, irq);
      else n_pass++;
    end
    address = 2'd0;
    tick();
    n_total++;
    if (readdata !== 32'hE) $display("FAIL clean_data got=%0h exp=e", readdata);
    else n_pass++;
  endtask

  task automatic test_bounce();
    av_write(2'd2, 32'hF);
    address = 2'd0;
    tick();
    for (int p = 0; p < 5; p++) begin
      for (int h = 0; h < 2; h++) begin
        in_port[2] = (h == 0) ? 1'b0 : 1'b1;
        repeat (3) begin
          tick();
          n_total++;
          if (readdata !== 32'hE) $display("FAIL bounce_data_glitch got=%0h exp=e", readdata);
          else n_pass++;
        end
      end
    end
    address = 2'd2;
    in_port[2] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 13) begin
        n_total++;
        if (readdata[2] !== 1'b0) $display("FAIL bounce_edge_early got=%b exp=0", readdata[2]);
        else n_pass++;
      end
      if (k == 14) begin
        n_total++;
        if (readdata[2] !== 1'b1) $display("FAIL bounce_edge_latency got=%b exp=1", readdata[2]);
        else n_pass++;
      end
    end
    n_total++;
    if (readdata !== 32'h4) $display("FAIL bounce_edgecap got=%0h exp=4", readdata);
    else n_pass++;
    address = 2'd0;
    tick();
    n_total++;
    if (readdata !== 32'hA) $display("FAIL bounce_data got=%0h exp=a", readdata);
    else n_pass++;
  endtask

  task automatic test_irq();
    in_port[0] = 1'b1;
    repeat (14) tick();
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_masked got=%b exp=0", irq);
    else n_pass++;
    av_write(2'd1, 32'h1);
    n_total++;
    if (irq !== 1'b1) $display("FAIL irq_mask_set got=%b exp=1", irq);
    else n_pass++;
    av_write(2'd2, 32'h1);
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_clear got=%b exp=0", irq);
    else n_pass++;
    in_port[0] = 1'b0;
    repeat (12) tick();
    n_total++;
    if (irq !== 1'b0) $display("FAIL irq_before_collision got=%b exp=0", irq);
    else n_pass++;
    av_write(2'd2, 32'h1);
    n_total++;
    if (irq !== 1'b1) $display("FAIL irq_set_wins got=%b exp=1", irq);
    else n_pass++;
    address = 2'd2;
    tick();
    n_total++;
    if (readdata[0] !== 1'b1 || irq !== 1'b1)
      $display("FAIL irq_edgecap_kept got=%b irq=%b exp=1", readdata[0], irq);
    else n_pass++;
    address = 2'd1;
    tick();
    n_total++;
    if (readdata !== 32'h1) $display("FAIL irq_mask_read got=%0h exp=1", readdata);
    else n_pass++;
  endtask

  task automatic test_period0();
    logic drv[0:31];
    av_write(2'd3, 32'd0);
    av_write(2'd2, 32'hF);
    av_write(2'd1, 32'h8);
    address = 2'd0;
    for (int k = 1; k <= 24; k++) begin
      if (k % 2 == 1) in_port[3] = ~in_port[3];
      drv[k] = in_port[3];
      tick();
      if (k >= 4) begin
        n_total++;
        if (readdata[3] !== drv[k-3]) $display("FAIL p0_follow k=%0d got=%b exp=%b", k, readdata[3], drv[k-3]);
        else n_pass++;
      end
    end
    repeat (4) tick();
    av_write(2'd2, 32'hF);
    n_total++;
    if (irq !== 1'b0) $display("FAIL p0_irq_idle got=%b exp=0", irq);
    else n_pass++;
    for (int t = 0; t < 4; t++) begin
      in_port[3] = ~in_port[3];
      repeat (4) tick();
      n_total++;
      if (irq !== 1'b1) $display("FAIL p0_toggle_edge t=%0d got=%b exp=1", t, irq);
      else n_pass++;
      av_write(2'd2, 32'h8);
      n_total++;
      if (irq !== 1'b0) $display("FAIL p0_toggle_clear t=%0d got=%b exp=0", t, irq);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    av_write(2'd3, 32'd10);
    av_write(2'd1, 32'hF);
    in_port = 4'h0;
    repeat (20) tick();
    n_total++;
    if (irq !== 1'b1) $display("FAIL mid_irq_before got=%b exp=1", irq);
    else n_pass++;
    in_port = 4'hF;
    repeat (6) tick();
    address = 2'd3;
    tick();
    n_total++;
    if (readdata !== 32'd10) $display("FAIL mid_period_before got=%0d exp=10", readdata);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if (readdata !== 32'd0 || irq !== 1'b0)
      $display("FAIL mid_reset_immediate rd=%0h irq=%b exp=0", readdata, irq);
    else n_pass++;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    address = 2'd2;
    for (int k = 1; k <= 100; k++) begin
      tick();
      n_total++;
      if (readdata !== 32'd0 || irq !== 1'b0 || readdata !== m_rd)
        $display("FAIL mid_no_spurious k=%0d rd=%0h irq=%b exp=0", k, readdata, irq);
      else n_pass++;
    end
    address = 2'd0;
    tick();
    n_total++;
    if (readdata !== 32'd0) $display("FAIL mid_data_after got=%0h exp=0", readdata);
    else n_pass++;
  endtask

  task automatic test_random();
    int fails_here = 0;
    av_write(2'd3, 32'd3);
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 3) == 0) in_port = 4'($urandom);
      address = 2'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = (address == 2'd3) ? 32'($urandom_range(0, 6)) : $urandom;
      end else begin
        chipselect = 1'($urandom);
        write_n    = 1'b1;
        writedata  = $urandom;
      end
      tick();
      n_total++;
      if (readdata !== m_rd || irq !== |(m_edgecap & m_mask)) begin
        if (fails_here < 10)
          $display("FAIL random k=%0d rd=%0h exp=%0h irq=%b exp=%b", k, readdata, m_rd, irq, |(m_edgecap & m_mask));
        fails_here++;
      end else n_pass++;
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_edge();
    test_bounce();
    test_irq();
    test_period0();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
